// File: rtl/f8_mem_pkg.sv
// Shared types and widths for the f8 two-port memory arbiter.
package f8_mem_pkg;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned BANK_AW = 15;
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned BYTE_W  = 8;
    localparam int unsigned BE_W    = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic {
        PRI0   = 1'b0,
        FORCE1 = 1'b1
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    // One port's request payload as seen by the bank mapper.
    typedef struct packed {
        logic [BE_W-1:0]   be;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/f8_bank_map.sv
// Maps a 16-bit byte-addressed access onto the even/odd byte banks.
module f8_bank_map
    import f8_mem_pkg::*;
(
    input  logic [ADDR_W-1:0]  i_addr,
    input  logic [BE_W-1:0]    i_be,
    input  logic [DATA_W-1:0]  i_wdata,
    output logic [BANK_AW-1:0] o_addr_even,
    output logic [BANK_AW-1:0] o_addr_odd,
    output logic [BYTE_W-1:0]  o_wdata_even,
    output logic [BYTE_W-1:0]  o_wdata_odd,
    output logic               o_we_even,
    output logic               o_we_odd,
    output logic               o_swap
);

    logic [BANK_AW-1:0] w_word;

    assign w_word = i_addr[ADDR_W-1:1];
    assign o_swap = i_addr[0];

    // Odd address: low byte lands in the odd bank, high byte in the next even word (15-bit wrap).
    always_comb begin
        o_addr_odd   = w_word;
        o_addr_even  = w_word;
        o_wdata_even = i_wdata[BYTE_W-1:0];
        o_wdata_odd  = i_wdata[DATA_W-1:BYTE_W];
        o_we_even    = i_be[0];
        o_we_odd     = i_be[1];
        if (o_swap) begin
            o_addr_even  = w_word + BANK_AW'(1);
            o_wdata_odd  = i_wdata[BYTE_W-1:0];
            o_wdata_even = i_wdata[DATA_W-1:BYTE_W];
            o_we_odd     = i_be[0];
            o_we_even    = i_be[1];
        end
    end

endmodule

// File: rtl/f8_mem_arbiter.sv
// Two-port arbiter (CPU port 0 priority, starvation-protected port 1) onto the f8 dual-bank RAM.
module f8_mem_arbiter
    import f8_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               i_req0,
    input  logic               i_req1,
    input  logic [BE_W-1:0]    i_be0,
    input  logic [BE_W-1:0]    i_be1,
    input  logic [ADDR_W-1:0]  i_addr0,
    input  logic [ADDR_W-1:0]  i_addr1,
    input  logic [DATA_W-1:0]  i_wdata0,
    input  logic [DATA_W-1:0]  i_wdata1,
    output logic               o_gnt0,
    output logic               o_gnt1,
    output logic               o_rvalid0,
    output logic               o_rvalid1,
    output logic [DATA_W-1:0]  o_rdata0,
    output logic [DATA_W-1:0]  o_rdata1,
    output logic [BANK_AW-1:0] o_mem_addr_even,
    output logic [BANK_AW-1:0] o_mem_addr_odd,
    output logic [BYTE_W-1:0]  o_mem_wdata_even,
    output logic [BYTE_W-1:0]  o_mem_wdata_odd,
    output logic               o_mem_we_even,
    output logic               o_mem_we_odd,
    input  logic [BYTE_W-1:0]  i_mem_rdata_even,
    input  logic [BYTE_W-1:0]  i_mem_rdata_odd
);

    arb_state_t         r_state;
    arb_state_t         w_state_next;
    logic [CNT_W-1:0]   r_wait_cnt;
    logic [CNT_W-1:0]   w_wait_cnt_next;
    logic               w_gnt0;
    logic               w_gnt1;
    logic               w_any_gnt;
    mem_req_t           w_req0;
    mem_req_t           w_req1;
    mem_req_t           w_sel;
    logic               w_we_even;
    logic               w_we_odd;
    logic               w_swap;
    logic               r_rd_valid;
    port_id_t           r_rd_port;
    logic               r_rd_swap;
    logic [DATA_W-1:0]  w_rdata;

    // Arbitration state and starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= PRI0;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
        end
    end

    // Grant selection, starvation counting and next state; no grant while reset is high.
    always_comb begin
        w_state_next    = PRI0;
        w_wait_cnt_next = '0;
        w_gnt0          = 1'b0;
        w_gnt1          = 1'b0;
        if (!reset) begin
            unique case (r_state)
                PRI0: begin
                    if (i_req0) begin
                        w_gnt0 = 1'b1;
                    end else if (i_req1) begin
                        w_gnt1 = 1'b1;
                    end
                end
                FORCE1: begin
                    if (i_req1) begin
                        w_gnt1 = 1'b1;
                    end else if (i_req0) begin
                        w_gnt0 = 1'b1;
                    end
                end
                default: ;
            endcase
            // Port 1 waiting while port 0 is served counts toward the forced slot.
            if (i_req1 && !w_gnt1) begin
                w_wait_cnt_next = r_wait_cnt + CNT_W'(1);
            end
            if ((r_state == PRI0) && (w_wait_cnt_next >= CNT_W'(STARVE_LIMIT))) begin
                w_state_next = FORCE1;
            end
        end
    end

    assign o_gnt0    = w_gnt0;
    assign o_gnt1    = w_gnt1;
    assign w_any_gnt = w_gnt0 | w_gnt1;

    assign w_req0 = {i_be0, i_addr0, i_wdata0};
    assign w_req1 = {i_be1, i_addr1, i_wdata1};
    assign w_sel  = w_gnt1 ? w_req1 : w_req0;

    f8_bank_map u_bank_map (
        .i_addr       (w_sel.addr),
        .i_be         (w_sel.be),
        .i_wdata      (w_sel.wdata),
        .o_addr_even  (o_mem_addr_even),
        .o_addr_odd   (o_mem_addr_odd),
        .o_wdata_even (o_mem_wdata_even),
        .o_wdata_odd  (o_mem_wdata_odd),
        .o_we_even    (w_we_even),
        .o_we_odd     (w_we_odd),
        .o_swap       (w_swap)
    );

    assign o_mem_we_even = w_we_even & w_any_gnt;
    assign o_mem_we_odd  = w_we_odd & w_any_gnt;

    // Remember which port issued a read and its lane swap for next-cycle reassembly.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_port  <= PORT0;
            r_rd_swap  <= 1'b0;
        end else begin
            r_rd_valid <= w_any_gnt && (w_sel.be == '0);
            if (w_any_gnt) begin
                r_rd_port <= w_gnt1 ? PORT1 : PORT0;
                r_rd_swap <= w_swap;
            end
        end
    end

    // Unswap the bank bytes into a little-endian halfword.
    assign w_rdata = r_rd_swap ? {i_mem_rdata_even, i_mem_rdata_odd}
                               : {i_mem_rdata_odd, i_mem_rdata_even};

    assign o_rdata0  = w_rdata;
    assign o_rdata1  = w_rdata;
    assign o_rvalid0 = r_rd_valid && (r_rd_port == PORT0) && !reset;
    assign o_rvalid1 = r_rd_valid && (r_rd_port == PORT1) && !reset;

endmodule
